// File: rtl/mux_4to1.sv
// mux_4to1: registered 4:1 selector with valid and select tracking.
// One-clock latency from capture to data_out/sel_out/out_valid; there is no
// combinational path from any input to any output.
// Optional feature: define MUX_4TO1_PARITY_EN to add the registered
// data_parity output (XOR of the bits loaded into data_out).
module mux_4to1 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    input  logic [WIDTH-1:0] data4,
    input  logic [1:0]       select,
    input  logic             in_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic [1:0]       sel_out
`ifdef MUX_4TO1_PARITY_EN
    ,
    output logic             data_parity
`endif
);

    logic [WIDTH-1:0] mux_data;

    // Combinational channel pick; every select code maps to a real input.
    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        mux_data = data1;
        case (select)
            2'd0: mux_data = data1;
            2'd1: mux_data = data2;
            2'd2: mux_data = data3;
            2'd3: mux_data = data4;
        endcase
    end

    // Output registers: reset clears, in_valid loads, otherwise data holds.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            data_out  <= '0;
            sel_out   <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= mux_data;
                sel_out  <= select;
            end
        end
    end

`ifdef MUX_4TO1_PARITY_EN
    // Parity register tracks data_out exactly: cleared on reset, loaded with it, held with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_parity <= 1'b0;
        end else if (in_valid) begin
            data_parity <= ^mux_data;
        end
    end
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: scoreboard bench for mux_4to1.
// The stimulus process pushes hand-computed expected results into a queue;
// a monitor pops and compares whenever out_valid is seen. Build with
// MUX_4TO1_PARITY_EN defined to also check data_parity.
module tb_mux_4to1;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [1:0]       sel;
        logic             parity;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data1, data2, data3, data4;
    logic [1:0]       select;
    logic             in_valid;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic [1:0]       sel_out;
`ifdef MUX_4TO1_PARITY_EN
    logic             data_parity;
`endif

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mux_4to1 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data1      (data1),
        .data2      (data2),
        .data3      (data3),
        .data4      (data4),
        .select     (select),
        .in_valid   (in_valid),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .sel_out    (sel_out)
`ifdef MUX_4TO1_PARITY_EN
        ,
        .data_parity(data_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one vector, optionally queue its expected result, then wait for
    // the sampling edge and return #1 after it.
    task automatic drive(input logic r, input logic iv, input logic [1:0] s,
                         input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                         input logic [WIDTH-1:0] d3, input logic [WIDTH-1:0] d4,
                         input logic [WIDTH-1:0] exp_data, input logic exp_par);
        exp_t e;
        rst      = r;
        in_valid = iv;
        select   = s;
        data1    = d1;
        data2    = d2;
        data3    = d3;
        data4    = d4;
        if (!r && iv) begin
            e.data   = exp_data;
            e.sel    = s;
            e.parity = exp_par;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name, input logic [WIDTH-1:0] exp_data,
                              input logic [1:0] exp_sel, input logic exp_par);
        check({name, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_data"},  {16'd0, data_out}, {16'd0, exp_data});
        check({name, "_sel"},   {30'd0, sel_out},  {30'd0, exp_sel});
`ifdef MUX_4TO1_PARITY_EN
        check({name, "_par"},   {31'd0, data_parity}, {31'd0, exp_par});
`else
        if (exp_par === 1'bx) check({name, "_par_arg"}, 32'd0, 32'd1);
`endif
    endtask

    // Monitor: on every negedge where out_valid is high, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", {16'd0, data_out}, {16'd0, e.data});
                    check("sb_sel",  {30'd0, sel_out},  {30'd0, e.sel});
`ifdef MUX_4TO1_PARITY_EN
                    check("sb_par",  {31'd0, data_parity}, {31'd0, e.parity});
`endif
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; select = 2'd0;
        data1 = '0; data2 = '0; data3 = '0; data4 = '0;

        // Reset for two cycles with arbitrary, valid-looking inputs.
        drive(1'b1, 1'b1, 2'd2, 16'hA5A5, 16'h1234, 16'hBEEF, 16'h7777, 16'd0, 1'b0);
        check_idle("reset1", 16'd0, 2'd0, 1'b0);
        drive(1'b1, 1'b1, 2'd3, 16'h5A5A, 16'h4321, 16'hCAFE, 16'h8888, 16'd0, 1'b0);
        check_idle("reset2", 16'd0, 2'd0, 1'b0);

        // Sweep, back-to-back, first edge with rst low is accepted.
        drive(1'b0, 1'b1, 2'd0, 16'd4095, 16'd61455, 16'd12345, 16'd20197, 16'd4095,  1'b0);
        check("sweep0_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 1'b1, 2'd1, 16'd4095, 16'd61455, 16'd12345, 16'd20197, 16'd61455, 1'b0);
        check("sweep1_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 1'b1, 2'd2, 16'd4095, 16'd61455, 16'd12345, 16'd20197, 16'd12345, 1'b0);
        check("sweep2_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 1'b1, 2'd3, 16'd4095, 16'd61455, 16'd12345, 16'd20197, 16'd20197, 1'b1);
        check("sweep3_valid", {31'd0, out_valid}, 32'd1);

        // Hold: capture channel 1, then drop in_valid and disturb inputs.
        drive(1'b0, 1'b1, 2'd1, 16'd4095, 16'd61455, 16'd12345, 16'd20197, 16'd61455, 1'b0);
        drive(1'b0, 1'b0, 2'd3, 16'd4095, 16'd0,     16'd12345, 16'd20197, 16'd0,     1'b0);
        check_idle("hold1", 16'd61455, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 2'd0, 16'd7,    16'd0,     16'd12345, 16'd20197, 16'd0,     1'b0);
        check_idle("hold2", 16'd61455, 2'd1, 1'b0);

        // Mid-stream reset discards the transfer on its edge.
        drive(1'b0, 1'b1, 2'd0, 16'd4095, 16'd61455, 16'd12345, 16'd20197, 16'd4095,  1'b0);
        drive(1'b1, 1'b1, 2'd2, 16'd4095, 16'd61455, 16'd12345, 16'd20197, 16'd0,     1'b0);
        check_idle("midrst", 16'd0, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 2'd2, 16'd4095, 16'd61455, 16'd12345, 16'd20197, 16'd12345, 1'b0);
        check("midrst_reload_valid", {31'd0, out_valid}, 32'd1);

        // Width edges on channel 3.
        drive(1'b0, 1'b1, 2'd3, 16'd1, 16'd2, 16'd3, 16'hFFFF, 16'd65535, 1'b0);
        drive(1'b0, 1'b1, 2'd3, 16'd1, 16'd2, 16'd3, 16'h0000, 16'd0,     1'b0);
        drive(1'b0, 1'b1, 2'd3, 16'd0, 16'd0, 16'd0, 16'h0001, 16'd1,     1'b1);
        drive(1'b0, 1'b0, 2'd0, 16'd9, 16'd9, 16'd9, 16'h0009, 16'd0,     1'b0);
        check_idle("edge_hold", 16'd1, 2'd3, 1'b1);

        // Drain: every queued expectation must have been consumed.
        drive(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        drive(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        check("sb_drain", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
